// File: rtl/nios_system_pio_gpio.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : nios_system_pio_gpio                                           |
// | Brief   : Avalon-MM GPIO with per-bit direction, set/clear, edge capture |
// |           and maskable level interrupt.                                  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module nios_system_pio_gpio #(
  parameter int          WIDTH     = 8,
  parameter logic [31:0] RESET_OUT = 32'h0,
  parameter logic [31:0] RESET_DIR = 32'h0,
  parameter int          EDGE_TYPE = 0
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [2:0]        address,
  input  logic              chipselect,
  input  logic              write_n,
  input  logic [31:0]       writedata,
  output logic [31:0]       readdata,
  input  logic [WIDTH-1:0]  in_port,
  output logic [WIDTH-1:0]  out_port,
  output logic [WIDTH-1:0]  oe_port,
  output logic              irq
);

  localparam logic [2:0] c_ADDR_DATA   = 3'd0;
  localparam logic [2:0] c_ADDR_DIR    = 3'd1;
  localparam logic [2:0] c_ADDR_MASK   = 3'd2;
  localparam logic [2:0] c_ADDR_EDGE   = 3'd3;
  localparam logic [2:0] c_ADDR_OUTSET = 3'd4;
  localparam logic [2:0] c_ADDR_OUTCLR = 3'd5;

  logic [WIDTH-1:0] r_data_out;
  logic [WIDTH-1:0] r_dir;
  logic [WIDTH-1:0] r_irq_mask;
  logic [WIDTH-1:0] r_edge_cap;
  logic [WIDTH-1:0] r_s1;
  logic [WIDTH-1:0] r_s2;
  logic [WIDTH-1:0] r_prev;
  logic             r_irq;

  logic             w_wr;
  logic [WIDTH-1:0] w_wdata;
  logic [WIDTH-1:0] w_edge;
  logic [WIDTH-1:0] w_clr;
  logic [WIDTH-1:0] w_data_out_nxt;
  logic [WIDTH-1:0] w_irq_mask_nxt;
  logic [WIDTH-1:0] w_edge_cap_nxt;
  logic             w_unused_wdata;

  assign w_wr           = chipselect & ~write_n;
  assign w_wdata        = writedata[WIDTH-1:0];
  assign w_unused_wdata = ^writedata;

  always_comb begin
    w_edge = r_s2 ^ r_prev;
    if (EDGE_TYPE == 0) begin
      w_edge = r_s2 & ~r_prev;
    end else if (EDGE_TYPE == 1) begin
      w_edge = ~r_s2 & r_prev;
    end
  end

  always_comb begin
    w_data_out_nxt = r_data_out;
    w_irq_mask_nxt = r_irq_mask;
    w_clr          = '0;
    if (w_wr) begin
      case (address)
        c_ADDR_DATA:   w_data_out_nxt = w_wdata;
        c_ADDR_MASK:   w_irq_mask_nxt = w_wdata;
        c_ADDR_EDGE:   w_clr          = w_wdata;
        c_ADDR_OUTSET: w_data_out_nxt = r_data_out | w_wdata;
        c_ADDR_OUTCLR: w_data_out_nxt = r_data_out & ~w_wdata;
        default: ;
      endcase
    end
  end

  // A freshly detected edge wins over a coincident write-1-to-clear.
  assign w_edge_cap_nxt = (r_edge_cap & ~w_clr) | w_edge;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_data_out <= RESET_OUT[WIDTH-1:0];
      r_dir      <= RESET_DIR[WIDTH-1:0];
      r_irq_mask <= '0;
      r_edge_cap <= '0;
      r_s1       <= '0;
      r_s2       <= '0;
      r_prev     <= '0;
      r_irq      <= 1'b0;
    end else begin
      r_data_out <= w_data_out_nxt;
      if (w_wr && (address == c_ADDR_DIR)) begin
        r_dir <= w_wdata;
      end
      r_irq_mask <= w_irq_mask_nxt;
      r_edge_cap <= w_edge_cap_nxt;
      r_s1       <= in_port;
      r_s2       <= r_s1;
      r_prev     <= r_s2;
      r_irq      <= |(w_edge_cap_nxt & w_irq_mask_nxt);
    end
  end

  always_comb begin
    readdata = '0;
    case (address)
      c_ADDR_DATA: readdata[WIDTH-1:0] = (r_dir & r_data_out) | (~r_dir & r_s2);
      c_ADDR_DIR:  readdata[WIDTH-1:0] = r_dir;
      c_ADDR_MASK: readdata[WIDTH-1:0] = r_irq_mask;
      c_ADDR_EDGE: readdata[WIDTH-1:0] = r_edge_cap;
      default: ;
    endcase
  end

  assign out_port = r_data_out;
  assign oe_port  = r_dir;
  assign irq      = r_irq;

endmodule
`default_nettype wire

// File: doc/nios_system_pio_gpio.md
Name: nios_system_pio_gpio

Overview:
- Parametrised general-purpose I/O peripheral on the Nios Avalon-MM bus; successor to the fixed 8-bit output-only PIO.
- Per-bit direction, atomic set/clear of outputs, 2-flop input synchronisation, per-bit edge capture and maskable level interrupt.
- Sits between the Avalon interconnect and board pins (LEDs, switches, keys). Pin tri-stating is done in the top level from oe_port.

Parameters:
- WIDTH, 8, number of I/O bits, 1..32.
- RESET_OUT, 0, reset value of data_out[WIDTH-1:0].
- RESET_DIR, 0, reset value of direction register; 1 = output.
- EDGE_TYPE, 0, capture mode: 0 rising, 1 falling, 2 any edge.

Ports:
- clk  input  1  system clock.
- reset_n  input  1  asynchronous active-low reset.
- address  input  3  register word address.
- chipselect  input  1  slave select.
- write_n  input  1  active-low write strobe.
- writedata  input  32  write data; bits above WIDTH ignored.
- readdata  output  32  read data; combinational, zero wait states; bits above WIDTH read 0.
- in_port  input  WIDTH  asynchronous pin inputs.
- out_port  output  WIDTH  output data register value.
- oe_port  output  WIDTH  direction register; 1 = drive pin.
- irq  output  1  level interrupt, active high.

Behaviour:
- Write strobe: wr = chipselect & ~write_n. A register updates on the clk rising edge when wr is high and address matches.
- Register map, word addresses:
  - 0 DATA: write loads data_out. Read returns per bit dir ? data_out : in_sync.
  - 1 DIR: read/write direction register.
  - 2 IRQ_MASK: read/write interrupt mask.
  - 3 EDGE_CAP: read returns capture bits. Writing 1 to a bit clears it; writing 0 leaves it unchanged.
  - 4 OUTSET: write does data_out |= writedata. Reads as 0.
  - 5 OUTCLR: write does data_out &= ~writedata. Reads as 0.
  - 6 and 7: reserved; read 0, writes ignored.
- Reset values, applied asynchronously: data_out=RESET_OUT, dir=RESET_DIR, irq_mask=0, edge_cap=0, sync/prev flops=0, irq=0.
- Synchroniser: in_port feeds s1, then s2 (in_sync), then prev.
  - Edge detect: rise = s2 & ~prev; fall = ~s2 & prev; any = s2 ^ prev. Selected by EDGE_TYPE.
- Edge capture:
  - A detected edge sets edge_cap[i] on the 3rd rising clk edge after in_port[i] changes, given setup is met at the 1st edge.
  - Edge detection runs regardless of dir; output bits still capture pin activity.
  - Set has priority over a W1C in the same cycle: the bit stays 1.
- irq is registered: irq <= |(edge_cap & irq_mask), using next-state values so irq changes in the same cycle as edge_cap or irq_mask. There is no extra latency beyond the register.
- Read-to-write timing: readdata reflects register values before the clock edge on which a coincident write lands.
- Boundary conditions:
  - Glitch of 1 cycle on in_port may or may not be captured; behaviour is undefined for pulses shorter than 1 clk.
  - Reset asserted mid-operation clears capture and irq immediately, without waiting for a clock edge.
  - After reset release, the first cycles do not generate a spurious edge because s2 = prev = 0. Exception: a pin held high produces a rising edge 2 cycles after release, which is required behaviour.
- Size: 120-250 lines expected; no FIFOs, no wait-states.

Test Plan:
1. Reset/defaults (WIDTH=8, RESET_OUT=8'hA5, RESET_DIR=8'hFF): assert reset_n=0 mid-cycle -> out_port=8'hA5, oe_port=8'hFF, irq=0 immediately; read addr 0 -> 32'h000000A5.
2. Set/clear: write DATA=8'h0F, OUTSET=8'hC0, OUTCLR=8'h03 -> out_port 8'h0F, then 8'hCF, then 8'hCC, each on the write's clock edge; read addr 4 -> 0.
3. Mixed direction: DIR=8'hF0, data_out=8'hAA, in_port=8'h55 held ≥3 cycles -> DATA read = 8'hA5.
4. Edge capture/irq (EDGE_TYPE=0): IRQ_MASK=8'h01; drive in_port[0] 0→1 -> edge_cap=8'h01 at 3rd edge, irq=1 same cycle. Drive in_port[1] 0→1 -> edge_cap=8'h03, irq stays 1. Write EDGE_CAP=8'h01 -> edge_cap=8'h02, irq=0.
5. Set-vs-clear race: time a W1C of bit 0 on the same edge a new rising edge on bit 0 is detected -> edge_cap[0]=1, irq stays 1.
6. Falling/any modes (EDGE_TYPE=1, then 2): pulse in_port[2] high 4 cycles -> mode 1: one capture on the fall only; mode 2: capture on the rise, W1C, then capture again on the fall. Reserved addr 6 write 32'hFFFFFFFF -> no register change.
